// File: rtl/divider_sched_21bits.sv
// Round-robin front end sharing one pipelined 21-bit divider among NUM_REQ requesters.
// Accept to div_open is 1 cycle, div_finish to rsp_valid is 1 cycle; requests stall only when MAX_INFLIGHT are outstanding.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign pop_ok  = pop_vld & ~empty;
  assign push_ok = push_vld & (cnt != CW'(DEPTH));
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

module divider_sched_21bits #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [21*NUM_REQ-1:0]      req_dividend,
  input  logic [21*NUM_REQ-1:0]      req_divisor,
  output logic                       div_open,
  output logic [20:0]                div_dividend,
  output logic [20:0]                div_divisor,
  input  logic                       div_finish,
  input  logic [20:0]                div_quotient,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [20:0]                rsp_quotient,
  output logic                       busy,
  output logic                       err_orphan
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_vld;
  logic           can_issue;
  logic           accept;
  logic           pop;
  logic           tag_empty;
  logic [IDW-1:0] tag_head;
  logic [CW-1:0]  inflight;
  int             idx;

  assign can_issue = (inflight < CW'(MAX_INFLIGHT));

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (can_issue && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign accept = can_issue & grant_vld;
  assign pop    = div_finish & ~tag_empty;
  assign busy   = (inflight != '0) | div_open;

  sync_fifo #(
    .W     (IDW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (accept),
    .push_dat (grant_idx),
    .pop_vld  (pop),
    .pop_dat  (tag_head),
    .empty    (tag_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_open     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      last_grant   <= IDW'(NUM_REQ - 1);
      inflight     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
      err_orphan   <= 1'b0;
    end else begin
      div_open <= accept;
      if (accept) begin
        div_dividend <= req_dividend[int'(grant_idx)*21 +: 21];
        div_divisor  <= req_divisor[int'(grant_idx)*21 +: 21];
        last_grant   <= grant_idx;
      end
      case ({accept, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      rsp_valid <= pop;
      if (pop) begin
        rsp_id       <= tag_head;
        rsp_quotient <= div_quotient;
      end
      // A finish with no tag outstanding is dropped and latched as an error.
      if (div_finish && tag_empty) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_divider_sched_21bits.sv
// Bench for divider_sched_21bits: queue-based requester/divider environment plus directed scenarios.
module tb_divider_sched_21bits;
  localparam int NR = 4;
  localparam int MI = 4;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [21*NR-1:0] req_dividend;
  logic [21*NR-1:0] req_divisor;
  logic             div_open;
  logic [20:0]      div_dividend;
  logic [20:0]      div_divisor;
  logic             div_finish;
  logic [20:0]      div_quotient;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [20:0]      rsp_quotient;
  logic             busy;
  logic             err_orphan;

  divider_sched_21bits #(.NUM_REQ(NR), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .div_open(div_open),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_finish(div_finish),
    .div_quotient(div_quotient), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .busy(busy), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qdiv(input int a, input int b);
    if (b == 0) return 0;
    return a / b;
  endfunction

  function automatic int sx(input logic [20:0] v);
    return int'($signed(v));
  endfunction

  int qa[NR][$];
  int qb[NR][$];
  int exp_ia[$], exp_ib[$], exp_rid[$], exp_rq[$];
  int glog_id[$], glog_cyc[$], rlog_id[$], rlog_q[$], rlog_cyc[$];
  logic [NR-1:0] accepted;
  int  model_out, lat, cyc;
  bit  orphan_m, fin_drv, force_fin, fin_ok, acc_any;
  bit  sched_v[64];
  int  sched_q[64];

  // Environment: model bookkeeping, checks, divider model and requesters all step on negedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_out = 0;
      orphan_m  = 1'b0;
      exp_ia.delete(); exp_ib.delete(); exp_rid.delete(); exp_rq.delete();
      for (int s = 0; s < 64; s++) sched_v[s] = 1'b0;
      accepted   = '0;
      fin_drv    = 1'b0;
      div_finish = 1'b0;
    end else begin
      fin_ok = fin_drv && (model_out > 0);
      if (fin_drv && !fin_ok) orphan_m = 1'b1;
      acc_any   = |accepted;
      model_out = model_out + int'(acc_any) - int'(fin_ok);

      chk("div_open", int'(div_open), int'(acc_any));
      if (div_open) begin
        if (exp_ia.size() == 0) chk("issue_unexpected", 1, 0);
        else begin
          chk("div_dividend", sx(div_dividend), exp_ia.pop_front());
          chk("div_divisor", sx(div_divisor), exp_ib.pop_front());
        end
      end
      chk("rsp_valid", int'(rsp_valid), int'(fin_ok));
      if (rsp_valid) begin
        if (exp_rid.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          chk("rsp_id", int'(rsp_id), exp_rid.pop_front());
          chk("rsp_quotient", sx(rsp_quotient), exp_rq.pop_front());
        end
        rlog_id.push_back(int'(rsp_id));
        rlog_q.push_back(sx(rsp_quotient));
        rlog_cyc.push_back(cyc);
      end
      chk("busy", int'(busy), int'(model_out != 0 || acc_any));
      chk("err_orphan", int'(err_orphan), int'(orphan_m));

      fin_drv      = sched_v[cyc % 64] | force_fin;
      div_finish   = fin_drv;
      div_quotient = sched_v[cyc % 64] ? 21'(sched_q[cyc % 64]) : 21'd0;
      sched_v[cyc % 64] = 1'b0;
      if (div_open) begin
        sched_v[(cyc + lat) % 64] = 1'b1;
        sched_q[(cyc + lat) % 64] = qdiv(sx(div_dividend), sx(div_divisor));
      end
    end

    for (int i = 0; i < NR; i++) begin
      if (accepted[i]) begin
        void'(qa[i].pop_front());
        void'(qb[i].pop_front());
      end
      req_valid[i] = (qa[i].size() != 0);
      if (qa[i].size() != 0) begin
        req_dividend[21*i +: 21] = 21'(qa[i][0]);
        req_divisor[21*i +: 21]  = 21'(qb[i][0]);
      end
    end

    if (rst_n) begin
      #1;
      chk("ready_count", $countones(req_ready), int'(model_out < MI && req_valid != '0));
      chk("ready_subset", int'(req_ready & ~req_valid), 0);
      accepted = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
        if (accepted[i]) begin
          exp_ia.push_back(qa[i][0]);
          exp_ib.push_back(qb[i][0]);
          exp_rid.push_back(i);
          exp_rq.push_back(qdiv(qa[i][0], qb[i][0]));
          glog_id.push_back(i);
          glog_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input int i, input int a, input int b);
    qa[i].push_back(a);
    qb[i].push_back(b);
  endtask

  task automatic clear_logs();
    glog_id.delete(); glog_cyc.delete();
    rlog_id.delete(); rlog_q.delete(); rlog_cyc.delete();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k;
    k = 0;
    while (rlog_id.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("rsp_count", rlog_id.size(), n);
  endtask

  task automatic check_outputs_reset(input string tag);
    chk({tag, "_div_open"}, int'(div_open), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_err_orphan"}, int'(err_orphan), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_div_dividend"}, int'(div_dividend), 0);
    chk({tag, "_div_divisor"}, int'(div_divisor), 0);
    chk({tag, "_rsp_quotient"}, int'(rsp_quotient), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
  endtask

  int rr_gid[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int rr_q[8]   = '{-10, -5, 4, 1048575, 3, 100, 0, -33};
  int lim_gid[6] = '{2, 3, 0, 1, 0, 1};
  int lim_q[6]   = '{11, -11, 5, 11, -5, -11};
  int rs_q[4]    = '{3, -3, -2, 2};

  initial begin
    rst_n = 1'b1; req_valid = '0; req_dividend = '0; req_divisor = '0;
    div_finish = 1'b0; div_quotient = '0; accepted = '0; lat = 2; force_fin = 1'b0;
    model_out = 0; cyc = 0; orphan_m = 1'b0; fin_drv = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_outputs_reset("reset");
    chk("reset_req_ready", int'(req_ready), 0);
    step(); step();
    rst_n = 1'b1;

    // Round robin: all four requesters with two requests each.
    clear_logs();
    push_req(0, -50, 5);     push_req(1, 21, -4);  push_req(2, -9, -2);  push_req(3, 1048575, 1);
    push_req(0, 7, 2);       push_req(1, 1000, 10); push_req(2, 0, 5);   push_req(3, -100, 3);
    wait_rsp(8, 60);
    chk("rr_grants", glog_id.size(), 8);
    for (int k = 0; k < 8 && k < glog_id.size(); k++) chk("rr_grant_order", glog_id[k], rr_gid[k]);
    if (glog_cyc.size() == 8) chk("rr_back_to_back", glog_cyc[7] - glog_cyc[0], 7);
    for (int k = 0; k < 8 && k < rlog_id.size(); k++) begin
      chk("rr_rsp_id", rlog_id[k], rr_gid[k]);
      chk("rr_rsp_q", rlog_q[k], rr_q[k]);
    end
    repeat (3) step();

    // Single request from requester 2.
    clear_logs();
    push_req(2, 100, 7);
    wait_rsp(1, 30);
    chk("single_grants", glog_id.size(), 1);
    if (glog_id.size() == 1 && rlog_id.size() == 1) begin
      chk("single_grant_id", glog_id[0], 2);
      chk("single_rsp_id", rlog_id[0], 2);
      chk("single_rsp_q", rlog_q[0], 14);
      chk("single_latency", rlog_cyc[0] - glog_cyc[0], 4);
    end
    repeat (3) step();

    // Divide by zero followed by a normal division on the same requester.
    clear_logs();
    push_req(1, 1234, 0);
    push_req(1, 9, 3);
    wait_rsp(2, 30);
    if (rlog_id.size() == 2) begin
      chk("dz_rsp_id0", rlog_id[0], 1);
      chk("dz_rsp_q0", rlog_q[0], 0);
      chk("dz_rsp_id1", rlog_id[1], 1);
      chk("dz_rsp_q1", rlog_q[1], 3);
    end
    repeat (3) step();

    // Inflight limit with a slow divider.
    lat = 10;
    clear_logs();
    push_req(0, 40, 8); push_req(0, -40, 8); push_req(1, 55, 5); push_req(1, 66, -6);
    push_req(2, 77, 7); push_req(3, 88, -8);
    wait_rsp(6, 80);
    chk("lim_grants", glog_id.size(), 6);
    if (glog_cyc.size() == 6) begin
      chk("lim_first4_span", glog_cyc[3] - glog_cyc[0], 3);
      chk("lim_5th_gap", glog_cyc[4] - glog_cyc[0], 12);
      chk("lim_6th_gap", glog_cyc[5] - glog_cyc[0], 13);
      for (int k = 0; k < 6; k++) chk("lim_grant_order", glog_id[k], lim_gid[k]);
    end
    for (int k = 0; k < 6 && k < rlog_q.size(); k++) chk("lim_rsp_q", rlog_q[k], lim_q[k]);
    repeat (3) step();

    // Orphan finish while idle.
    force_fin = 1'b1;
    step();
    force_fin = 1'b0;
    step();
    chk("orphan_flag", int'(err_orphan), 1);
    chk("orphan_rsp_valid", int'(rsp_valid), 0);
    chk("orphan_busy", int'(busy), 0);
    repeat (5) step();
    chk("orphan_sticky", int'(err_orphan), 1);

    // Reset with three operations in flight.
    clear_logs();
    push_req(1, 1000, 3); push_req(2, -1000, 7); push_req(3, 5, 5);
    for (int k = 0; k < 20 && glog_id.size() < 3; k++) step();
    chk("mr_issued", glog_id.size(), 3);
    step(); step();
    chk("mr_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_outputs_reset("midreset");
    step();
    clear_logs();
    push_req(0, 12, 4); push_req(1, -12, 4); push_req(2, 12, -5); push_req(3, -13, -5);
    step();
    rst_n = 1'b1;
    wait_rsp(4, 80);
    if (glog_id.size() >= 1) chk("mr_first_grant", glog_id[0], 0);
    for (int k = 0; k < 4 && k < rlog_id.size(); k++) begin
      chk("mr_rsp_id", rlog_id[k], k);
      chk("mr_rsp_q", rlog_q[k], rs_q[k]);
    end
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
